// File: rtl/pipemem_arbiter.sv
// Arbiter for the MEM-stage data bus, shared between the CPU MEM stage and an external port.
// The CPU wins contention until CPU_BURST grants; then the external port gets one slot.
module pipemem_arbiter #(
    parameter int CPU_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic        ext_rvalid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RUN = 2'd1,
        EXT_DUE = 2'd2
    } state_t;

    localparam logic [4:0] BURST = 5'(CPU_BURST);

    state_t      state;
    state_t      state_next;
    logic [3:0]  run_cnt;
    logic [3:0]  run_cnt_next;
    logic [4:0]  run_inc;
    logic        grant_cpu;
    logic        grant_ext;

    assign run_inc = {1'b0, run_cnt} + 5'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            run_cnt <= 4'd0;
        end else begin
            state   <= state_next;
            run_cnt <= run_cnt_next;
        end
    end

    // The counter saturates so a large CPU_BURST can never wrap back into a short episode.
    always_comb begin
        state_next   = state;
        run_cnt_next = run_cnt;
        if (grant_ext) begin
            state_next   = IDLE;
            run_cnt_next = 4'd0;
        end else if (grant_cpu && ext_req) begin
            if (run_cnt != 4'hF) begin
                run_cnt_next = run_cnt + 4'd1;
            end
            state_next = (run_inc == BURST) ? EXT_DUE : CPU_RUN;
        end else if (!ext_req) begin
            state_next   = IDLE;
            run_cnt_next = 4'd0;
        end
    end

    always_comb begin
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        if (!reset) begin
            grant_cpu = cpu_req && !(ext_req && state == EXT_DUE);
            grant_ext = ext_req && (!cpu_req || state == EXT_DUE);
        end
        cpu_stall = !reset && cpu_req && !grant_cpu;
        ext_ack   = grant_ext;
        bus_we    = 1'b0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        if (grant_ext) begin
            bus_we    = ext_we;
            bus_addr  = ext_addr;
            bus_wdata = ext_wdata;
        end else if (grant_cpu) begin
            bus_we    = cpu_we;
            bus_addr  = cpu_addr;
            bus_wdata = cpu_wdata;
        end
    end

    assign cpu_rdata = bus_rdata;

    // Read data is captured only for external reads; writes leave the last read value visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            ext_rdata  <= 32'd0;
            ext_rvalid <= 1'b0;
        end else begin
            ext_rvalid <= grant_ext && !ext_we;
            if (grant_ext && !ext_we) begin
                ext_rdata <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_pipemem_arbiter.sv
// Directed bench for pipemem_arbiter: one instance with CPU_BURST=4 on a small memory model,
// a second with CPU_BURST=1 for the alternating-grant case.
module tb_pipemem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic        cpu_stall, ext_ack, ext_rvalid, bus_we;
    logic [31:0] cpu_rdata, ext_rdata, bus_addr, bus_wdata, bus_rdata;

    logic        s_cpu_req, s_cpu_we, s_ext_req, s_ext_we;
    logic [31:0] s_cpu_addr, s_cpu_wdata, s_ext_addr, s_ext_wdata;
    logic        s_cpu_stall, s_ext_ack, s_ext_rvalid, s_bus_we;
    logic [31:0] s_cpu_rdata, s_ext_rdata, s_bus_addr, s_bus_wdata;
    logic [31:0] s_bus_rdata = 32'd0;

    logic [31:0] mem [0:63] = '{default: 32'h0};

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    pipemem_arbiter #(.CPU_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    pipemem_arbiter #(.CPU_BURST(1)) dut_sat (
        .clock(clock), .reset(reset),
        .cpu_req(s_cpu_req), .cpu_we(s_cpu_we), .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
        .cpu_stall(s_cpu_stall), .cpu_rdata(s_cpu_rdata),
        .ext_req(s_ext_req), .ext_we(s_ext_we), .ext_addr(s_ext_addr), .ext_wdata(s_ext_wdata),
        .ext_ack(s_ext_ack), .ext_rdata(s_ext_rdata), .ext_rvalid(s_ext_rvalid),
        .bus_we(s_bus_we), .bus_addr(s_bus_addr), .bus_wdata(s_bus_wdata), .bus_rdata(s_bus_rdata)
    );

    // Word-addressed memory/I-O model behind the bus: combinational read, write at the edge.
    assign bus_rdata = mem[bus_addr[7:2]];
    always @(posedge clock) begin
        if (bus_we) mem[bus_addr[7:2]] <= bus_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                                 input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed);
        @(posedge clock);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    endtask

    // Hold cpu_req and ext_req together; CPU owns cycles 0-3, ext gets cycle 4.
    task automatic contend(input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                           input logic cw, input logic rvalid_first);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, cw, 32'h84 + 32'(4 * i), 32'h11110000 + 32'(i), 1'b1, ew, ea, ed);
            @(negedge clock);
            if (i < 4) begin
                checkOutput($sformatf("cont_ack_%0d", i), 32'(ext_ack), 32'd0);
                checkOutput($sformatf("cont_stall_%0d", i), 32'(cpu_stall), 32'd0);
                checkOutput($sformatf("cont_addr_%0d", i), bus_addr, 32'h84 + 32'(4 * i));
                checkOutput($sformatf("cont_we_%0d", i), 32'(bus_we), 32'(cw));
                checkOutput($sformatf("cont_rvalid_%0d", i), 32'(ext_rvalid), (i == 0) ? 32'(rvalid_first) : 32'd0);
            end else begin
                checkOutput("cont_ext_ack", 32'(ext_ack), 32'd1);
                checkOutput("cont_ext_stall", 32'(cpu_stall), 32'd1);
                checkOutput("cont_ext_addr", bus_addr, ea);
                checkOutput("cont_ext_we", 32'(bus_we), 32'(ew));
                checkOutput("cont_ext_wdata", bus_wdata, ed);
            end
        end
    endtask

    initial begin
        int ack_count;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h90; ext_wdata = 32'h66;
        s_cpu_req = 1'b0; s_cpu_we = 1'b0; s_cpu_addr = 32'd0; s_cpu_wdata = 32'd0;
        s_ext_req = 1'b0; s_ext_we = 1'b0; s_ext_addr = 32'd0; s_ext_wdata = 32'd0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
            checkOutput("rst_ext_ack", 32'(ext_ack), 32'd0);
            checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'd0);
            checkOutput("rst_bus_addr", bus_addr, 32'd0);
            checkOutput("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
            checkOutput("rst_ext_rdata", ext_rdata, 32'd0);
        end

        @(posedge clock);
        #1;
        reset = 1'b0;
        cpu_we = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
        @(negedge clock);
        checkOutput("post_rst_addr", bus_addr, 32'h20);
        checkOutput("post_rst_stall", 32'(cpu_stall), 32'd0);
        checkOutput("post_rst_ack", 32'(ext_ack), 32'd0);

        applyStimulus(1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        checkOutput("cpu_st_we", 32'(bus_we), 32'd1);
        checkOutput("cpu_st_addr", bus_addr, 32'h10);
        checkOutput("cpu_st_wdata", bus_wdata, 32'h12345678);
        checkOutput("cpu_st_stall", 32'(cpu_stall), 32'd0);

        applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        checkOutput("cpu_ld_we", 32'(bus_we), 32'd0);
        checkOutput("cpu_ld_addr", bus_addr, 32'h10);
        checkOutput("cpu_ld_rdata", cpu_rdata, 32'h12345678);
        checkOutput("cpu_ld_stall", 32'(cpu_stall), 32'd0);

        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5);
        @(negedge clock);
        checkOutput("ext_wr_ack", 32'(ext_ack), 32'd1);
        checkOutput("ext_wr_we", 32'(bus_we), 32'd1);
        checkOutput("ext_wr_addr", bus_addr, 32'h80);
        checkOutput("ext_wr_wdata", bus_wdata, 32'hA5A5A5A5);

        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h80, 32'd0);
        @(negedge clock);
        checkOutput("ext_rd_ack", 32'(ext_ack), 32'd1);
        checkOutput("ext_rd_we", 32'(bus_we), 32'd0);
        checkOutput("ext_wr_no_rvalid", 32'(ext_rvalid), 32'd0);

        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        checkOutput("ext_rd_rvalid", 32'(ext_rvalid), 32'd1);
        checkOutput("ext_rd_rdata", ext_rdata, 32'hA5A5A5A5);
        checkOutput("idle_ack", 32'(ext_ack), 32'd0);
        checkOutput("idle_bus_addr", bus_addr, 32'd0);

        // CPU stores 0x11110000+i to 0x84+4i while ext reads back the cycle-1 store.
        contend(1'b0, 32'h88, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        checkOutput("cont_cpu_again_addr", bus_addr, 32'h40);
        checkOutput("cont_cpu_again_stall", 32'(cpu_stall), 32'd0);
        checkOutput("cont_rvalid", 32'(ext_rvalid), 32'd1);
        checkOutput("cont_rdata", ext_rdata, 32'h11110001);

        contend(1'b0, 32'h8C, 32'd0, 1'b0, 1'b0);
        contend(1'b1, 32'h8C, 32'hDEADBEEF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        checkOutput("rw_no_rvalid", 32'(ext_rvalid), 32'd0);
        checkOutput("rw_rdata_held", ext_rdata, 32'h11110002);

        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h8C, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        checkOutput("rw_written_rvalid", 32'(ext_rvalid), 32'd1);
        checkOutput("rw_written_rdata", ext_rdata, 32'hDEADBEEF);

        // CPU_BURST=1 instance: grants must alternate CPU, ext, CPU, ext...
        ack_count = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            s_cpu_req = 1'b1; s_cpu_addr = 32'h100 + 32'(4 * i);
            s_ext_req = 1'b1; s_ext_addr = 32'h80;
            @(negedge clock);
            if (s_ext_ack) ack_count++;
            checkOutput($sformatf("sat_ack_%0d", i), 32'(s_ext_ack), 32'(i % 2));
            checkOutput($sformatf("sat_stall_%0d", i), 32'(s_cpu_stall), 32'(i % 2));
            checkOutput($sformatf("sat_addr_%0d", i), s_bus_addr,
                        (i % 2 == 1) ? 32'h80 : 32'h100 + 32'(4 * i));
        end
        checkOutput("sat_ack_count", 32'(ack_count), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipemem_arbiter.md
# pipemem_arbiter

Single-cycle arbiter that shares the MEM-stage data bus (data memory at addr[7]=0, I/O registers at addr[7]=1) between the pipelined CPU's MEM stage and an external requester such as a program loader or debug port. It sits between the MEM pipeline register and the memory/I/O mux. It grants at most one access per clock. It stalls the CPU only on contention, and it guarantees the external port a grant within a bounded number of cycles.

## Interface
- CPU_BURST, default 4: maximum consecutive CPU grants while ext_req is pending; legal range 1–15.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  MEM stage performs a load or store this cycle.
- cpu_we  in  1  CPU store.
- cpu_addr  in  32  CPU byte address (malu).
- cpu_wdata  in  32  CPU store data (mb).
- cpu_stall  out  1  freeze IF/ID/EX/MEM registers; high when cpu_req and the CPU is not granted.
- cpu_rdata  out  32  bus_rdata passed through, combinational.
- ext_req  in  1  external access request; held with ext_we, ext_addr and ext_wdata stable until ext_ack.
- ext_we  in  1  external write.
- ext_addr  in  32  external byte address.
- ext_wdata  in  32  external write data.
- ext_ack  out  1  one-cycle pulse in the cycle the external access is performed.
- ext_rdata  out  32  registered read data for the acknowledged access.
- ext_rvalid  out  1  one-cycle pulse, the cycle after ext_ack of a read.
- bus_we  out  1  write strobe to the memory/I/O side; zero when there is no grant.
- bus_addr  out  32  address of the granted requester; zero when there is no grant.
- bus_wdata  out  32  write data of the granted requester; zero when there is no grant.
- bus_rdata  in  32  read data from the memory/I/O mux, valid in the same cycle.

## Operation
- States:
  - IDLE: no contention history.
  - CPU_RUN: CPU is granted while ext_req is pending.
  - EXT_DUE: burst limit reached; ext wins the next contended cycle.
- Counter run_cnt, 4 bits, counts CPU grants in the current contention episode.
- Per-cycle grant, combinational from state and requests:
  - Neither request: no grant, bus_we=0, bus_addr=0, bus_wdata=0.
  - cpu_req only: CPU granted.
  - ext_req only: ext granted.
  - Both requests, state ≠ EXT_DUE: CPU granted.
  - Both requests, state = EXT_DUE: ext granted, cpu_stall=1.
- Transitions, evaluated at the clock edge:
  - Ext granted: state←IDLE, run_cnt←0.
  - CPU granted and ext_req high: run_cnt←run_cnt+1, state←CPU_RUN. If run_cnt+1 = CPU_BURST, state←EXT_DUE instead.
  - ext_req low and not granted: state←IDLE, run_cnt←0.
  - A withdrawn ext_req is not legal and is not checked. The FSM simply returns to IDLE.
- bus_we = granted requester's we. The write strobe is not otherwise gated; downstream logic applies the ~clock phase gating and the addr[7] decode.
- Ext read: when ext is granted with ext_we=0, ext_rdata←bus_rdata at the edge and ext_rvalid=1 in the next cycle.
- Ext write: ext_rvalid stays 0 and ext_rdata is held.
- run_cnt saturates and never wraps. The EXT_DUE state blocks any further CPU grant while ext_req is pending.

## Timing
- Reset, checked at the first edge with reset=1:
  - state=IDLE, run_cnt=0, ext_rdata=0, ext_rvalid=0.
- While reset is high:
  - All grants are forced off: cpu_stall=0, ext_ack=0, bus_we=0, bus_addr=0, bus_wdata=0.
- Reset mid-access: a pending ext access is dropped without ack. The requester keeps ext_req high and is served after reset is released.
- No contention: zero added latency. cpu_stall=0, and the CPU access completes in the same cycle.
- Worst-case ext wait, measured from ext_req rising: CPU_BURST cycles, with ack in cycle CPU_BURST+1.
- Worst-case CPU stall per ext access: 1 cycle.
- Back-to-back ext requests under contention: after an ext grant the CPU again gets up to CPU_BURST grants. The ratio is therefore CPU_BURST:1.
- ext_rvalid follows ext_ack of a read by exactly 1 cycle. ext_rdata stays stable until the next ext read completes.

## Test plan
- Reset: assert reset with both requests high for 2 cycles. Required: bus_we=0, ext_ack=0, cpu_stall=0, ext_rvalid=0. After release with cpu_req only, the CPU is granted in the first cycle.
- CPU only: store 0x12345678 to 0x00000010, then load 0x00000010. Required: bus_we=1 then 0, bus_addr=0x10 in both cycles, cpu_rdata=0x12345678, cpu_stall=0 throughout.
- Ext only: ext write of 0xA5A5A5A5 to 0x80, then ext read of 0x80. Required: ext_ack on the same cycle as each request. For the read, ext_rvalid=1 one cycle later with ext_rdata=0xA5A5A5A5 (I/O output register readback through the bench model).
- Contention, CPU_BURST=4: cpu_req held high, ext_req raised in cycle 0. Required:
  - CPU granted in cycles 0–3.
  - Ext granted in cycle 4, with cpu_stall=1 only in cycle 4.
  - CPU granted again in cycle 5.
- Saturation: CPU_BURST=1, both requests held high for 10 cycles. Required: grants alternate CPU, ext, CPU, ext, …, with exactly 5 ext_ack pulses.
- Ext read followed by ext write under contention. Required: ext_rvalid pulses only for the read, and ext_rdata is unchanged after the write.
